// File: rtl/num_syst.sv
// num_syst: number-system display for 8 switches, two push buttons and
// four 7-segment digits. KEY1 loads the switch byte. KEY0 cycles the
// display base through HEX, DEC and OCT. The latched byte is shown on
// digits 0..2, a base letter on digit 3, and the raw byte on the LEDs.
module num_syst #(
   parameter bit SEG_ACTIVE_LOW = 1'b1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       KEY0,
   input  logic       KEY1,
   input  logic [7:0] switches,
   output logic [6:0] hex0,
   output logic [6:0] hex1,
   output logic [6:0] hex2,
   output logic [6:0] hex3,
   output logic [7:0] leds,
   output logic [1:0] base
);

   typedef enum logic [1:0] {
      MODE_HEX  = 2'd0,
      MODE_DEC  = 2'd1,
      MODE_OCT  = 2'd2,
      MODE_RSVD = 2'd3
   } mode_t;

   // Lit-segment masks, bit 0 = a ... bit 6 = g.
   localparam logic [6:0] SEG_BLANK  = 7'h00;
   localparam logic [6:0] SEG_LTR_H  = 7'h76;
   localparam logic [6:0] SEG_LTR_D  = 7'h5E;
   localparam logic [6:0] SEG_LTR_O  = 7'h5C;

   // ------------------------------------------------------------------
   // Button conditioning
   // ------------------------------------------------------------------
   logic [1:0] key_raw;
   logic [1:0] press;

   assign key_raw = {KEY1, KEY0};

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_key
         logic s1_reg;
         logic s2_reg;
         logic prev_reg;
         logic v1_reg;
         logic v2_reg;
         logic arm_reg;

         // Synchronize the key and keep the previous synchronized level.
         // The arm flag is only set once a genuinely sampled released level
         // has reached s2, so a key that is held down through reset is not
         // mistaken for a fresh press when reset lifts.
         always_ff @(posedge clk) begin
            if (rst) begin
               s1_reg   <= 1'b1;
               s2_reg   <= 1'b1;
               prev_reg <= 1'b1;
               v1_reg   <= 1'b0;
               v2_reg   <= 1'b0;
               arm_reg  <= 1'b0;
            end else begin
               s1_reg   <= key_raw[gi];
               s2_reg   <= s1_reg;
               prev_reg <= s2_reg;
               v1_reg   <= 1'b1;
               v2_reg   <= v1_reg;
               arm_reg  <= arm_reg | (v2_reg & s2_reg);
            end
         end

         // One-cycle pulse on the synchronized falling edge.
         assign press[gi] = arm_reg & prev_reg & ~s2_reg;
      end
   endgenerate

   // ------------------------------------------------------------------
   // Value and mode registers
   // ------------------------------------------------------------------
   logic [7:0] value_reg;
   mode_t      mode_reg;
   mode_t      mode_next;

   // Base sequence; the unused encoding behaves like HEX.
   always_comb begin
      mode_next = mode_reg;
      if (press[0]) begin
         case (mode_reg)
            MODE_HEX: mode_next = MODE_DEC;
            MODE_DEC: mode_next = MODE_OCT;
            MODE_OCT: mode_next = MODE_HEX;
            default:  mode_next = MODE_DEC;
         endcase
      end
   end

   // Latch switches on KEY1 and step the base on KEY0; both may fire together.
   always_ff @(posedge clk) begin
      if (rst) begin
         value_reg <= 8'h00;
         mode_reg  <= MODE_HEX;
      end else begin
         if (press[1]) begin
            value_reg <= switches;
         end
         mode_reg <= mode_next;
      end
   end

   assign leds = value_reg;
   assign base = mode_reg;

   // ------------------------------------------------------------------
   // Digit formatting
   // ------------------------------------------------------------------
   function automatic logic [6:0] seg_lit(input logic [3:0] d);
      logic [6:0] m;
      case (d)
         4'h0: m = 7'h3F;
         4'h1: m = 7'h06;
         4'h2: m = 7'h5B;
         4'h3: m = 7'h4F;
         4'h4: m = 7'h66;
         4'h5: m = 7'h6D;
         4'h6: m = 7'h7D;
         4'h7: m = 7'h07;
         4'h8: m = 7'h7F;
         4'h9: m = 7'h6F;
         4'hA: m = 7'h77;
         4'hB: m = 7'h7C;
         4'hC: m = 7'h39;
         4'hD: m = 7'h5E;
         4'hE: m = 7'h79;
         default: m = 7'h71;
      endcase
      return m;
   endfunction

   // Shift-and-add-3 conversion of a byte to three BCD digits.
   function automatic logic [11:0] bin2bcd(input logic [7:0] bin);
      logic [19:0] sh;
      sh = {12'd0, bin};
      for (int i = 0; i < 8; i++) begin
         if (sh[11:8]  >= 4'd5) sh[11:8]  = sh[11:8]  + 4'd3;
         if (sh[15:12] >= 4'd5) sh[15:12] = sh[15:12] + 4'd3;
         if (sh[19:16] >= 4'd5) sh[19:16] = sh[19:16] + 4'd3;
         sh = sh << 1;
      end
      return sh[19:8];
   endfunction

   logic [11:0] bcd;
   logic [3:0]  dig_h;
   logic [3:0]  dig_t;
   logic [3:0]  dig_u;
   logic [6:0]  lit [0:3];

   // Choose digits and letter per base, applying leading-zero blanking
   // to the DEC and OCT forms; HEX always shows both nibbles.
   always_comb begin
      bcd   = bin2bcd(value_reg);
      dig_h = 4'd0;
      dig_t = 4'd0;
      dig_u = 4'd0;
      lit[3] = SEG_LTR_H;
      lit[2] = SEG_BLANK;
      lit[1] = seg_lit(value_reg[7:4]);
      lit[0] = seg_lit(value_reg[3:0]);
      if (mode_reg == MODE_DEC || mode_reg == MODE_OCT) begin
         if (mode_reg == MODE_DEC) begin
            dig_h  = bcd[11:8];
            dig_t  = bcd[7:4];
            dig_u  = bcd[3:0];
            lit[3] = SEG_LTR_D;
         end else begin
            dig_h  = {2'b00, value_reg[7:6]};
            dig_t  = {1'b0, value_reg[5:3]};
            dig_u  = {1'b0, value_reg[2:0]};
            lit[3] = SEG_LTR_O;
         end
         lit[2] = (dig_h == 4'd0) ? SEG_BLANK : seg_lit(dig_h);
         lit[1] = (dig_h == 4'd0 && dig_t == 4'd0) ? SEG_BLANK : seg_lit(dig_t);
         lit[0] = seg_lit(dig_u);
      end
   end

   // Apply output polarity to each digit.
   logic [6:0] seg_out [0:3];

   generate
      for (gi = 0; gi < 4; gi++) begin : g_pol
         assign seg_out[gi] = SEG_ACTIVE_LOW ? ~lit[gi] : lit[gi];
      end
   endgenerate

   assign hex0 = seg_out[0];
   assign hex1 = seg_out[1];
   assign hex2 = seg_out[2];
   assign hex3 = seg_out[3];

endmodule

// File: tb/tb_num_syst.sv
// tb_num_syst: directed test of num_syst. The stimulus process pushes the
// hand-computed expected display into a scoreboard queue and raises a
// check strobe; a separate monitor pops and compares on the falling edge.
module tb_num_syst;

   logic       clk;
   logic       rst;
   logic       key0;
   logic       key1;
   logic [7:0] switches;
   logic [6:0] hex0, hex1, hex2, hex3;
   logic [7:0] leds;
   logic [1:0] base;

   num_syst #(.SEG_ACTIVE_LOW(1'b1)) dut (
      .clk      (clk),
      .rst      (rst),
      .KEY0     (key0),
      .KEY1     (key1),
      .switches (switches),
      .hex0     (hex0),
      .hex1     (hex1),
      .hex2     (hex2),
      .hex3     (hex3),
      .leds     (leds),
      .base     (base)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Active-low segment codes, written out by hand.
   localparam logic [6:0] S0 = 7'h40, S1 = 7'h79, S2 = 7'h24, S3 = 7'h30;
   localparam logic [6:0] S4 = 7'h19, S5 = 7'h12, S6 = 7'h02, S7 = 7'h78;
   localparam logic [6:0] S8 = 7'h00, SA = 7'h08, SB = 7'h03;
   localparam logic [6:0] BL = 7'h7F, LH = 7'h09, LD = 7'h21, LO = 7'h23;

   typedef struct packed {
      logic [7:0] leds;
      logic [1:0] base;
      logic [6:0] h3;
      logic [6:0] h2;
      logic [6:0] h1;
      logic [6:0] h0;
   } exp_t;

   exp_t  exp_q [$];
   string tag_q [$];
   bit    chk_req = 1'b0;
   int    total = 0;
   int    bad = 0;

   task automatic cmp(input string tag, input string field,
                      input logic [7:0] act, input logic [7:0] want);
      total++;
      if (act !== want) begin
         bad++;
         $display("FAIL %s.%s: got %h, expected %h", tag, field, act, want);
      end
   endtask

   // Monitor: compare DUT outputs against the next scoreboard entry.
   always @(negedge clk) begin
      if (chk_req) begin
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL scoreboard: check requested with empty queue");
         end else begin
            exp_t  e;
            string t;
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            cmp(t, "leds", leds, e.leds);
            cmp(t, "base", {6'd0, base}, {6'd0, e.base});
            cmp(t, "hex3", {1'b0, hex3}, {1'b0, e.h3});
            cmp(t, "hex2", {1'b0, hex2}, {1'b0, e.h2});
            cmp(t, "hex1", {1'b0, hex1}, {1'b0, e.h1});
            cmp(t, "hex0", {1'b0, hex0}, {1'b0, e.h0});
            $display("check %s: leds=%h base=%0d hex3..0=%h %h %h %h",
                     t, leds, base, hex3, hex2, hex1, hex0);
         end
      end
   end

   // Queue an expectation and have the monitor check it at the next falling edge.
   task automatic expect_state(input string tag, input logic [7:0] l,
                               input logic [1:0] b, input logic [6:0] h3,
                               input logic [6:0] h2, input logic [6:0] h1,
                               input logic [6:0] h0);
      exp_t e;
      e = '{leds: l, base: b, h3: h3, h2: h2, h1: h1, h0: h0};
      exp_q.push_back(e);
      tag_q.push_back(tag);
      chk_req = 1'b1;
      @(negedge clk);
      #1 chk_req = 1'b0;
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Press the keys in mask (bit0 = KEY0, bit1 = KEY1) for three edges,
   // which completes the action, then release and let the conditioner settle.
   task automatic press(input logic [1:0] mask);
      if (mask[0]) key0 = 1'b0;
      if (mask[1]) key1 = 1'b0;
      tick(3);
      key0 = 1'b1;
      key1 = 1'b1;
      tick(4);
   endtask

   task automatic load(input logic [7:0] v);
      switches = v;
      press(2'b10);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      key0 = 1'b1;
      key1 = 1'b1;
      switches = 8'h00;
      tick(3);
      expect_state("reset", 8'h00, 2'd0, LH, BL, S0, S0);
      rst = 1'b0;
      tick(4);

      // Load with a two-cycle hold: value appears on the third edge only.
      switches = 8'h20;
      key1 = 1'b0;
      tick(2);
      key1 = 1'b1;
      expect_state("load_edge2", 8'h00, 2'd0, LH, BL, S0, S0);
      tick(1);
      expect_state("load_edge3", 8'h20, 2'd0, LH, BL, S2, S0);
      tick(4);

      // Long hold: one latch only, later switch changes are ignored.
      switches = 8'h5A;
      key1 = 1'b0;
      tick(3);
      expect_state("hold_latch", 8'h5A, 2'd0, LH, BL, S5, SA);
      switches = 8'h99;
      tick(5);
      expect_state("hold_norelatch", 8'h5A, 2'd0, LH, BL, S5, SA);
      key1 = 1'b1;
      tick(5);
      expect_state("release_nothing", 8'h5A, 2'd0, LH, BL, S5, SA);

      // Base cycling with 0x20.
      load(8'h20);
      press(2'b01);
      expect_state("dec_32", 8'h20, 2'd1, LD, BL, S3, S2);
      press(2'b01);
      expect_state("oct_40", 8'h20, 2'd2, LO, BL, S4, S0);
      press(2'b01);
      expect_state("hex_20", 8'h20, 2'd0, LH, BL, S2, S0);

      // DEC boundaries.
      press(2'b01);
      load(8'hFF);
      expect_state("dec_255", 8'hFF, 2'd1, LD, S2, S5, S5);
      load(8'h80);
      expect_state("dec_128", 8'h80, 2'd1, LD, S1, S2, S8);
      load(8'h0F);
      expect_state("dec_15", 8'h0F, 2'd1, LD, BL, S1, S5);
      load(8'h00);
      expect_state("dec_0", 8'h00, 2'd1, LD, BL, BL, S0);

      // OCT boundaries.
      press(2'b01);
      load(8'hFF);
      expect_state("oct_377", 8'hFF, 2'd2, LO, S3, S7, S7);
      load(8'h1F);
      expect_state("oct_37", 8'h1F, 2'd2, LO, BL, S3, S7);
      load(8'h11);
      expect_state("oct_21", 8'h11, 2'd2, LO, BL, S2, S1);
      load(8'h16);
      expect_state("oct_26", 8'h16, 2'd2, LO, BL, S2, S6);

      // Back to HEX, then a letter-digit value.
      press(2'b01);
      expect_state("hex_16", 8'h16, 2'd0, LH, BL, S1, S6);
      load(8'hAB);
      expect_state("hex_ab", 8'hAB, 2'd0, LH, BL, SA, SB);

      // Both keys in the same cycle.
      switches = 8'h32;
      press(2'b11);
      expect_state("both_keys", 8'h32, 2'd1, LD, BL, S5, S0);

      // Reset while a KEY0 press is one edge from firing, key held afterwards.
      key0 = 1'b0;
      tick(2);
      rst = 1'b1;
      tick(2);
      expect_state("rst_midpress", 8'h00, 2'd0, LH, BL, S0, S0);
      rst = 1'b0;
      tick(6);
      expect_state("rst_held_key", 8'h00, 2'd0, LH, BL, S0, S0);
      key0 = 1'b1;
      tick(5);
      press(2'b01);
      expect_state("after_rst_press", 8'h00, 2'd1, LD, BL, BL, S0);

      if (exp_q.size() != 0) begin
         total++;
         bad++;
         $display("FAIL scoreboard: %0d expectations never checked", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
